// File: rtl/div_sequencer_if.sv
// Handshake/operand bus between the EX-stage controller and the divider.
interface div_sequencer_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [1:0]      divctl;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   // EX-stage controller side
   modport master (
      output start, divctl, op_a, op_b, flush,
      input  busy, done, result
   );

   // divider side
   modport slave (
      input  start, divctl, op_a, op_b, flush,
      output busy, done, result
   );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for RV32M div/divu/rem/remu with its sequencing FSM.
// Divides operand magnitudes, then applies sign correction; divide-by-zero and
// signed overflow bypass the iterations and finish one edge after accept.
module div_sequencer #(
   parameter int XLEN = 32
) (
   input logic           clk,
   input logic           rst,
   div_sequencer_if.slave bus
);
   localparam int              CW     = $clog2(XLEN);
   localparam logic [CW-1:0]   L_CNT0 = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] L_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t          r_state, w_next;
   logic [1:0]      r_ctl;
   logic            r_sa, r_sb;
   logic [XLEN-1:0] r_quo;       // dividend bits shift out, quotient bits shift in
   logic [XLEN-1:0] r_div;       // divisor magnitude
   logic [XLEN-1:0] r_rem;       // partial remainder; always < divisor so XLEN bits suffice
   logic [CW-1:0]   r_cnt;
   logic            r_spec;
   logic [XLEN-1:0] r_spec_res;
   logic            r_done;
   logic [XLEN-1:0] r_result;

   logic            w_accept, w_iter, w_complete;
   logic            w_signed, w_div0, w_ovf;
   logic [XLEN-1:0] w_a_mag, w_b_mag, w_spec_res;
   logic [XLEN:0]   w_shift, w_diff;
   logic            w_ge;
   logic [XLEN-1:0] w_q, w_r, w_fin;

   // accept-time operand decode and special-case results
   always_comb begin
      w_signed   = ~bus.divctl[0];
      w_a_mag    = (w_signed && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
      w_b_mag    = (w_signed && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
      w_div0     = (bus.op_b == '0);
      w_ovf      = w_signed && (bus.op_a == L_MIN) && (bus.op_b == '1);
      w_spec_res = '0;
      if (w_div0)
         w_spec_res = bus.divctl[1] ? bus.op_a : '1;
      else if (w_ovf)
         w_spec_res = bus.divctl[1] ? '0 : L_MIN;
   end

   // one restoring step: shift in next dividend bit, trial-subtract with a sign bit
   always_comb begin
      w_shift = {r_rem, r_quo[XLEN-1]};
      w_diff  = w_shift - {1'b0, r_div};
      w_ge    = ~w_diff[XLEN];
   end

   // sign correction and quotient/remainder select at completion
   always_comb begin
      w_q   = (~r_ctl[0] && (r_sa ^ r_sb)) ? -r_quo : r_quo;
      w_r   = (~r_ctl[0] && r_sa) ? -r_rem : r_rem;
      w_fin = r_spec ? r_spec_res : (r_ctl[1] ? w_r : w_q);
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state logic; flush wins over everything
   always_comb begin
      w_next = r_state;
      if (bus.flush) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (bus.start) w_next = (w_div0 || w_ovf) ? S_FIN : S_CALC;
            S_CALC:  if (r_cnt == '0) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // per-state datapath enables
   always_comb begin
      w_accept   = (r_state == S_IDLE) && bus.start && !bus.flush;
      w_iter     = (r_state == S_CALC) && !bus.flush;
      w_complete = (r_state == S_FIN)  && !bus.flush;
   end

   // datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctl      <= '0;
         r_sa       <= 1'b0;
         r_sb       <= 1'b0;
         r_quo      <= '0;
         r_div      <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
         r_spec     <= 1'b0;
         r_spec_res <= '0;
         r_done     <= 1'b0;
         r_result   <= '0;
      end else begin
         r_done <= w_complete;
         if (w_complete) r_result <= w_fin;
         if (w_accept) begin
            r_ctl      <= bus.divctl;
            r_sa       <= bus.op_a[XLEN-1];
            r_sb       <= bus.op_b[XLEN-1];
            r_quo      <= w_a_mag;
            r_div      <= w_b_mag;
            r_rem      <= '0;
            r_cnt      <= L_CNT0;
            r_spec     <= w_div0 || w_ovf;
            r_spec_res <= w_spec_res;
         end
         if (w_iter) begin
            r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign bus.busy   = (r_state != S_IDLE);
   assign bus.done   = r_done;
   assign bus.result = r_result;
endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: arithmetic reference model with a cycle-countdown
// latency model, per-cycle compare, plus literal expectations per directed vector.
module tb_div_sequencer;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   div_sequencer_if #(.XLEN(XLEN)) bus ();

   div_sequencer #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // RISC-V M-extension result from plain arithmetic
   function automatic logic [31:0] ref_div(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return c[1] ? a : 32'hFFFF_FFFF;
      if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return c[1] ? 32'd0 : 32'h8000_0000;
      if (c[0]) return c[1] ? (a % b) : (a / b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return c[1] ? r[31:0] : q[31:0];
   endfunction

   function automatic bit is_short(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // model: busy counts down the latency from accept, done pulses at zero
   logic        m_busy = 1'b0, m_done = 1'b0;
   logic [31:0] m_res = '0, m_pend = '0;
   int          m_cnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_res  <= '0;
         m_cnt  <= 0;
      end else begin
         m_done <= 1'b0;
         if (bus.flush) begin
            m_busy <= 1'b0;
         end else if (m_busy) begin
            if (m_cnt == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_res  <= m_pend;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end else if (bus.start) begin
            m_busy <= 1'b1;
            m_pend <= ref_div(bus.divctl, bus.op_a, bus.op_b);
            m_cnt  <= is_short(bus.divctl, bus.op_a, bus.op_b) ? 1 : XLEN + 1;
         end
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      n_vec = n_vec + 3;
      if (bus.busy !== m_busy) begin
         n_err = n_err + 1;
         $display("FAIL cyc_busy t=%0t got %b want %b", $time, bus.busy, m_busy);
      end
      if (bus.done !== m_done) begin
         n_err = n_err + 1;
         $display("FAIL cyc_done t=%0t got %b want %b", $time, bus.done, m_done);
      end
      if (bus.result !== m_res) begin
         n_err = n_err + 1;
         $display("FAIL cyc_result t=%0t got %h want %h", $time, bus.result, m_res);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // drive one start cycle; returns at accept edge + 1
   task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.divctl = c; bus.op_a = a; bus.op_b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // wait for done (bounded), k0 edges already elapsed since accept
   task automatic wait_done(input logic [31:0] exp_res, input int exp_lat, input string nm, input int k0);
      int k;
      k = k0;
      while (!bus.done && k < 80) begin
         @(posedge clk); #1;
         k++;
      end
      chk({nm, "_lat"}, k, exp_lat);
      chk({nm, "_res"}, bus.result, exp_res);
   endtask

   task automatic run_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input string nm);
      issue(c, a, b);
      chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd1);
      wait_done(exp_res, exp_lat, nm, 0);
   endtask

   initial begin
      bus.start = 1'b0; bus.divctl = 2'b00; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
      chk("rst_done",   {31'd0, bus.done}, 32'd0);
      chk("rst_result", bus.result, 32'd0);
      #10 rst = 1'b0;

      // main function
      run_op(2'b01, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
      run_op(2'b10, 32'd100, 32'd7, 32'd2,  33, "rem_100_7");
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 33, "remu_fff9_2");
      run_op(2'b00, 32'd20, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 33, "div_20_m5");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");

      // divide by zero
      run_op(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_5_0");
      run_op(2'b01, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, "divu_0_0");
      run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, "rem_m5_0");
      run_op(2'b11, 32'd5, 32'd0, 32'd5, 1, "remu_5_0");

      // signed overflow
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
      run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_ovf_ops");

      // start while busy is ignored
      issue(2'b01, 32'd1000, 32'd10);
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.divctl = 2'b00; bus.op_a = 32'd7; bus.op_b = 32'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(32'd100, 33, "busy_start", 5);

      // flush at iteration 10
      issue(2'b00, 32'd12345, 32'd3);
      repeat (9) @(posedge clk);
      #1 bus.flush = 1'b1;
      bus.start = 1'b1; bus.op_a = 32'd8; bus.op_b = 32'd2;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.start = 1'b0;
      chk("flush_busy",   {31'd0, bus.busy}, 32'd0);
      chk("flush_done",   {31'd0, bus.done}, 32'd0);
      chk("flush_result", bus.result, 32'd100);
      repeat (40) @(posedge clk);
      #1 chk("flush_hold", bus.result, 32'd100);
      run_op(2'b01, 32'd9, 32'd3, 32'd3, 33, "divu_9_3");

      // flush coinciding with the completion edge
      issue(2'b01, 32'd1000, 32'd10);
      repeat (32) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      chk("finflush_done",   {31'd0, bus.done}, 32'd0);
      chk("finflush_busy",   {31'd0, bus.busy}, 32'd0);
      chk("finflush_result", bus.result, 32'd3);
      repeat (5) @(posedge clk);

      // back-to-back: start in the done cycle
      issue(2'b01, 32'd50, 32'd5);
      wait_done(32'd10, 33, "b2b_first", 0);
      bus.start = 1'b1; bus.divctl = 2'b01; bus.op_a = 32'd60; bus.op_b = 32'd4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
      wait_done(32'd15, 33, "b2b_second", 0);

      // asynchronous reset mid-CALC
      issue(2'b00, 32'd1000, 32'd10);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_busy",   {31'd0, bus.busy}, 32'd0);
      chk("arst_done",   {31'd0, bus.done}, 32'd0);
      chk("arst_result", bus.result, 32'd0);
      #3 rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("arst_nodone", {31'd0, bus.busy}, 32'd0);
      chk("arst_hold",   bus.result, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle iterative divider and its sequencing FSM for the RV32M div/divu/rem/remu instructions.
- Sits in the EX stage beside the ALU and multiplier. The EX-stage controller decodes func3/func7 into divctl and pulses start; the pipeline stalls while busy is high.
- Uses radix-2 restoring division on operand magnitudes, then applies sign correction and the RISC-V special-case results.

Parameters:
XLEN, 32, operand/result width in bits (≥4)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous and active-high
start  input  1  request a new divide operation; sampled on clk
divctl  input  2  operation select: 00 div, 01 divu, 10 rem, 11 remu; sampled with start
op_a  input  XLEN  dividend (rs1); sampled with start
op_b  input  XLEN  divisor (rs2); sampled with start
flush  input  1  synchronous abort of any in-flight operation
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result is valid in that cycle
result  output  XLEN  quotient or remainder of the last completed operation

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, all internal registers cleared. Asserting reset mid-operation aborts the operation; no done is issued after reset releases.
- States: IDLE, CALC, FIN. busy = (state != IDLE). All outputs are registered.
- done defaults to 0 every edge; only the completing edge sets it to 1.
- Accept: start=1 while state=IDLE (including the cycle in which done=1) at edge E0.
  - Latch divctl.
  - signed = ~divctl[0].
  - Latch |op_a| and |op_b| when signed, raw values otherwise; record sign(op_a) and sign(op_b).
  - Load the XLEN+1-bit partial remainder with 0 and the iteration counter with XLEN-1.
- start while busy=1 is ignored; the in-flight operation is unaffected.
- Special cases, decided at E0:
  - Divisor zero: quotient = all ones; remainder = op_a unmodified (signed and unsigned).
  - Signed overflow (div/rem with op_a=0x80..0, op_b=all ones): quotient = 0x80..0; remainder = 0.
  - For either case, state→FIN at E0. At E1 result is loaded, done=1, and state→IDLE. Latency: done is high in the cycle after E1.
- CALC: one iteration per edge E1..EXLEN.
  - Shift {rem, quo} left by 1, shifting in the MSB of the dividend.
  - Trial-subtract the divisor (XLEN+1 bits). If non-negative, keep the difference and set the quotient LSB to 1; else restore and set it to 0.
  - The counter decrements each iteration; at counter=0, state→FIN.
- FIN (normal path): at EXLEN+1, apply sign correction and load result, set done=1, state→IDLE.
  - Signed quotient is negated iff sign(a)≠sign(b).
  - Signed remainder takes the sign of op_a.
  - divctl[1] selects the remainder, else the quotient.
  - Normal latency: done is high after XLEN+1 edges from the accept edge (33 for XLEN=32).
- result holds its value between completions; it is unchanged by flush and by ignored starts.
- flush=1: state→IDLE at the next edge, busy→0, done stays 0, and result is unchanged. flush has priority over start in the same cycle; that start is dropped.
- flush in the same cycle as the FIN completion edge: completion is suppressed (done=0, result unchanged).
- Back-to-back operation: start in the done cycle is accepted at that edge; busy returns to 1 in the next cycle.
- Arithmetic is modulo 2^XLEN; negating 0x80..0 yields 0x80..0.

Test Plan:
- divu op_a=100, op_b=7 -> after start edge, busy=1 for 33 cycles, then done=1 for exactly one cycle with result=14. rem on the same operands -> result=2.
- div op_a=-7 (0xFFFFFFF9), op_b=2 -> result=0xFFFFFFFD (-3). rem op_a=-7, op_b=2 -> result=0xFFFFFFFF (-1). remu op_a=0xFFFFFFF9, op_b=2 -> result=1.
- Divide by zero -> done one cycle after E1. div 5/0 -> 0xFFFFFFFF. divu 0/0 -> 0xFFFFFFFF. rem -5/0 -> 0xFFFFFFFB. remu 5/0 -> 5.
- Signed overflow div 0x80000000/0xFFFFFFFF -> result=0x80000000 at short latency. rem on the same operands -> 0. divu on the same operands -> 0 at full 33-cycle latency.
- Hazard stimulus:
  - start with new operands while busy -> ignored; the original result is delivered.
  - flush at iteration 10 -> busy=0 next cycle, no done, result holds the previous value; the following divu 9/3 -> 3.
  - start asserted in the done cycle -> the second op is accepted and completes 33 cycles later.
- Assert rst asynchronously mid-CALC (between clock edges) -> busy=0, done=0, result=0 immediately. After release, no done appears without a new start.
